// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// Buffered UART transmitter. Words enter a small FIFO through a valid/ready
// handshake and are sent as frames: start bit, DATA_BITS payload bits
// (LSB first), an optional parity bit, then STOP_BITS stop bits. When more
// words are waiting, frames follow each other with no idle gap on the line.
//
// Ports
//   clk        : system clock, the only clock of the block
//   reset      : synchronous, active-high reset
//   data_in    : word to transmit
//   data_valid : data_in is presented
//   data_ready : FIFO can accept a word this cycle (combinational, !full)
//   tx         : UART line, idle high, driven from a register
//   tx_busy    : a frame is on the line (stays high across back-to-back frames)
//   fifo_count : number of words stored in the FIFO
// -----------------------------------------------------------------------------
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 6,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;

    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);
    localparam logic [AW:0]   ZERO_CNT  = (AW + 1)'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit of a payload word: even mode sends the XOR, odd mode its inverse.
    function automatic logic f_parity(input logic [DATA_BITS-1:0] word);
        logic p;
        p = ^word;
        if (PARITY_MODE == 2) begin
            f_parity = ~p;
        end else begin
            f_parity = p;
        end
    endfunction

    // FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic [AW:0]          w_count_nxt;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // Transmitter
    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;
    logic                 w_last_tick;
    logic                 w_last_stop;

    assign w_full      = (r_count == FULL_CNT);
    assign data_ready  = ~w_full;
    assign w_push      = data_valid & ~w_full;
    assign w_head      = r_mem[r_rptr];
    assign w_last_tick = (r_timer == LAST_TICK);
    assign w_last_stop = w_last_tick & (r_bit_idx == LAST_STOP);

    assign tx         = r_tx;
    assign tx_busy    = r_busy;
    assign fifo_count = r_count;

    // Pop decision: a word leaves the FIFO when a frame starts, either from idle
    // or at the end of the previous frame's last stop bit.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = (r_count != ZERO_CNT);
            end
            ST_STOP: begin
                w_pop = (r_count != ZERO_CNT) & w_last_stop;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // Occupancy update: a push and a pop on the same edge cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10: begin
                w_count_nxt = r_count + ONE_CNT;
            end
            2'b01: begin
                w_count_nxt = r_count - ONE_CNT;
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // Payload storage; entries are only meaningful between write and read pointer.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= ZERO_CNT;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Frame sequencer: bit timing, shift register, and registered tx / tx_busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= {TW{1'b0}};
            r_bit_idx <= {BW{1'b0}};
            r_shift   <= {DATA_BITS{1'b0}};
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx    <= 1'b1;
                    r_timer <= {TW{1'b0}};
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= f_parity(w_head);
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_last_tick) begin
                        r_timer   <= {TW{1'b0}};
                        r_bit_idx <= {BW{1'b0}};
                        r_state   <= ST_DATA;
                        // Present bit 0 now and pre-shift so r_shift[0] is always the next bit.
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_last_tick) begin
                        r_timer <= {TW{1'b0}};
                        if (r_bit_idx == LAST_DATA) begin
                            r_bit_idx <= {BW{1'b0}};
                            if (PARITY_MODE != 0) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_last_tick) begin
                        r_timer   <= {TW{1'b0}};
                        r_bit_idx <= {BW{1'b0}};
                        r_state   <= ST_STOP;
                        r_tx      <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_last_tick) begin
                        r_timer <= {TW{1'b0}};
                        if (r_bit_idx == LAST_STOP) begin
                            r_bit_idx <= {BW{1'b0}};
                            // A waiting word starts immediately so frames stay contiguous.
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= f_parity(w_head);
                                r_state <= ST_START;
                                r_tx    <= 1'b0;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_timer   <= {TW{1'b0}};
                    r_bit_idx <= {BW{1'b0}};
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_stream
// Three instances with different frame formats share clock and reset; one is
// exercised at a time (sel). A reference model turns every accepted word into
// the expected per-cycle line waveform and tracks the expected FIFO occupancy.
// -----------------------------------------------------------------------------
module tb_uart_tx_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [8:0] drv_data;
    logic       drv_valid;
    int         sel;

    logic       val_a, val_b, val_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    assign val_a = drv_valid && (sel == 0);
    assign val_b = drv_valid && (sel == 1);
    assign val_c = drv_valid && (sel == 2);

    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .data_in(drv_data[7:0]), .data_valid(val_a),
        .data_ready(rdy_a), .tx(tx_a), .tx_busy(busy_a), .fifo_count(cnt_a));

    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .data_in(drv_data[7:0]), .data_valid(val_b),
        .data_ready(rdy_b), .tx(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b));

    uart_tx_stream #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(2)) u_c (
        .clk(clk), .reset(reset), .data_in(drv_data[6:0]), .data_valid(val_c),
        .data_ready(rdy_c), .tx(tx_c), .tx_busy(busy_c), .fifo_count(cnt_c));

    int cfg_cpb [3] = '{4, 4, 3};
    int cfg_db  [3] = '{8, 8, 7};
    int cfg_pm  [3] = '{1, 2, 0};
    int cfg_sb  [3] = '{1, 2, 1};
    int cfg_dep [3] = '{4, 4, 2};

    logic lit_a [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic lit_c [9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic       exp_bits  [$];
    bit         exp_start [$];
    int         m_count;
    logic [8:0] src_q [$];

    logic       last_tx, last_busy, last_acc;
    logic [2:0] last_cnt;
    bit         seen_not_ready;
    int         max_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(output logic t, output logic b, output logic r, output logic [2:0] n);
        case (sel)
            0:       begin t = tx_a; b = busy_a; r = rdy_a; n = cnt_a; end
            1:       begin t = tx_b; b = busy_b; r = rdy_b; n = cnt_b; end
            default: begin t = tx_c; b = busy_c; r = rdy_c; n = {1'b0, cnt_c}; end
        endcase
    endtask

    // Expand one word into its frame waveform, one entry per clock cycle.
    task automatic add_frame(input logic [8:0] w);
        logic fb [$];
        logic p;
        p = 1'b0;
        fb.push_back(1'b0);
        for (int i = 0; i < cfg_db[sel]; i++) begin
            fb.push_back(w[i]);
            p = p ^ w[i];
        end
        if (cfg_pm[sel] == 1) fb.push_back(p);
        else if (cfg_pm[sel] == 2) fb.push_back(~p);
        for (int i = 0; i < cfg_sb[sel]; i++) fb.push_back(1'b1);
        foreach (fb[k]) begin
            for (int c = 0; c < cfg_cpb[sel]; c++) begin
                exp_bits.push_back(fb[k]);
                exp_start.push_back(k == 0 && c == 0);
            end
        end
    endtask

    // One clock cycle: check ready, advance the model, check line and count.
    task automatic step(input logic rst);
        logic o_tx, o_busy, o_rdy, e_tx, e_busy, acc;
        logic [2:0] o_cnt;
        sample(o_tx, o_busy, o_rdy, o_cnt);
        chk("data_ready", 32'(o_rdy), 32'(m_count < cfg_dep[sel]));
        if (!o_rdy) seen_not_ready = 1'b1;
        acc = drv_valid && !rst && (m_count < cfg_dep[sel]);
        reset = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_bits.delete();
            exp_start.delete();
            m_count = 0;
            e_tx    = 1'b1;
            e_busy  = 1'b0;
        end else begin
            if (exp_bits.size() > 0) begin
                e_tx   = exp_bits.pop_front();
                e_busy = 1'b1;
                if (exp_start.pop_front()) m_count--;
            end else begin
                e_tx   = 1'b1;
                e_busy = 1'b0;
            end
            if (acc) begin
                m_count++;
                add_frame(drv_data);
            end
        end
        sample(o_tx, o_busy, o_rdy, o_cnt);
        chk("tx", 32'(o_tx), 32'(e_tx));
        chk("tx_busy", 32'(o_busy), 32'(e_busy));
        chk("fifo_count", 32'(o_cnt), 32'(m_count));
        if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
        last_tx   = o_tx;
        last_busy = o_busy;
        last_cnt  = o_cnt;
        last_acc  = acc;
    endtask

    // Feed src_q (gap_pct = chance of an idle cycle before each word) and drain.
    task automatic run(input int budget, input int gap_pct);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_bits.size() > 0 || m_count > 0) && n < budget) begin
            if (src_q.size() > 0 && !drv_valid && int'($urandom_range(99)) >= gap_pct) begin
                drv_valid = 1'b1;
                drv_data  = src_q[0];
            end
            step(1'b0);
            if (last_acc) begin
                void'(src_q.pop_front());
                drv_valid = 1'b0;
                drv_data  = 9'($urandom);
            end
            n++;
        end
        drv_valid = 1'b0;
        chk("drain_within_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        logic t, b, r;
        logic [2:0] n;
        int busy_cnt;

        reset     = 1'b1;
        drv_valid = 1'b0;
        drv_data  = 9'd0;
        sel       = 0;
        m_count   = 0;
        max_cnt   = 0;
        seen_not_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state of every instance
        for (int s = 0; s < 3; s++) begin
            sel = s;
            sample(t, b, r, n);
            chk("reset_tx", 32'(t), 32'd1);
            chk("reset_busy", 32'(b), 32'd0);
            chk("reset_count", 32'(n), 32'd0);
            chk("reset_ready", 32'(r), 32'd1);
        end

        // 0xA5, even parity: first push on the first edge after reset release
        sel = 0;
        drv_valid = 1'b1;
        drv_data  = 9'h0A5;
        step(1'b0);
        drv_valid = 1'b0;
        drv_data  = 9'h15A;
        chk("a5_accepted", 32'(last_cnt), 32'd1);
        chk("a5_tx_high_at_accept", 32'(last_tx), 32'd1);
        busy_cnt = 0;
        for (int c = 0; c < 44; c++) begin
            step(1'b0);
            chk("a5_bit", 32'(last_tx), 32'(lit_a[c / 4]));
            if (last_busy) busy_cnt++;
        end
        step(1'b0);
        chk("a5_idle_after", 32'(last_tx), 32'd1);
        chk("a5_busy_len", 32'(busy_cnt), 32'd44);
        chk("a5_busy_drop", 32'(last_busy), 32'd0);

        // Push and pop on the same edge with two words stored
        for (int k = 0; k < 3; k++) begin
            drv_valid = 1'b1;
            drv_data  = 9'($urandom);
            step(1'b0);
        end
        drv_valid = 1'b0;
        repeat (42) step(1'b0);
        drv_valid = 1'b1;
        drv_data  = 9'($urandom);
        step(1'b0);
        drv_valid = 1'b0;
        chk("same_edge_count", 32'(last_cnt), 32'd2);
        run(1000, 0);

        // Six words back-to-back into a 4-deep FIFO
        seen_not_ready = 1'b0;
        max_cnt = 0;
        for (int k = 0; k < 6; k++) src_q.push_back(9'($urandom));
        run(2000, 0);
        chk("burst_ready_low_seen", 32'(seen_not_ready), 32'd1);
        chk("burst_max_count", 32'(max_cnt), 32'd4);

        // Reset during DATA bit 3 with a second word queued
        drv_valid = 1'b1;
        drv_data  = 9'($urandom);
        step(1'b0);
        drv_data  = 9'($urandom);
        step(1'b0);
        drv_valid = 1'b0;
        repeat (17) step(1'b0);
        step(1'b1);
        chk("midreset_tx", 32'(last_tx), 32'd1);
        chk("midreset_busy", 32'(last_busy), 32'd0);
        chk("midreset_count", 32'(last_cnt), 32'd0);
        drv_valid = 1'b1;
        drv_data  = 9'h03C;
        step(1'b0);
        drv_valid = 1'b0;
        chk("post_reset_accept", 32'(last_cnt), 32'd1);
        run(1000, 0);

        // Random traffic on the even-parity instance
        for (int k = 0; k < 25; k++) src_q.push_back(9'($urandom));
        run(6000, 60);

        // 0x01, odd parity, two stop bits
        sel = 1;
        drv_valid = 1'b1;
        drv_data  = 9'h001;
        step(1'b0);
        drv_valid = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 48; c++) begin
            step(1'b0);
            if (c >= 36 && c < 40) chk("odd_parity_bit", 32'(last_tx), 32'd0);
            if (c >= 40) chk("two_stop_bits", 32'(last_tx), 32'd1);
            if (last_busy) busy_cnt++;
        end
        step(1'b0);
        chk("b_busy_len", 32'(busy_cnt), 32'd48);
        chk("b_busy_drop", 32'(last_busy), 32'd0);
        for (int k = 0; k < 15; k++) src_q.push_back(9'($urandom));
        run(4000, 50);

        // 0x55, 7 data bits, no parity
        sel = 2;
        drv_valid = 1'b1;
        drv_data  = 9'h055;
        step(1'b0);
        drv_valid = 1'b0;
        for (int c = 0; c < 27; c++) begin
            step(1'b0);
            chk("c_bit", 32'(last_tx), 32'(lit_c[c / 3]));
        end
        step(1'b0);
        chk("c_idle_after", 32'(last_busy), 32'd0);
        seen_not_ready = 1'b0;
        for (int k = 0; k < 20; k++) src_q.push_back(9'($urandom));
        run(3000, 30);
        chk("c_full_seen", 32'(seen_not_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
